// File: rtl/reader_sequencer.sv
// Picks one char-stream reader per job, arms and pause-gates it, and buffers its
// chars in a small FIFO presented downstream as a valid/ready stream.
module reader_sequencer #(
   parameter int N_READERS = 4,
   parameter int SEL_W     = 2,
   parameter int CHAR_W    = 8,
   parameter int DEPTH     = 4,
   parameter int DROP_NUL  = 0,
   parameter int TIMEOUT   = 1023
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          start,
   input  logic [SEL_W-1:0]              source_sel,
   input  logic [7:0]                    argument,
   input  logic                          abort,
   output logic [N_READERS-1:0]          reader_enable,
   output logic [7:0]                    reader_argument,
   output logic                          reader_pause,
   input  logic [N_READERS-1:0]          reader_finished,
   input  logic [N_READERS*CHAR_W-1:0]   reader_char,
   output logic [CHAR_W-1:0]             out_char,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [7:0]             arg_q, arg_d;
   logic                   issued_q, issued_d;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [N_READERS-1:0]   enable_q, enable_d;
   logic                   pause_q, busy_q, done_q, error_q;
   logic                   err_d, flush, wr_en, pop;
   logic                   sel_fin;
   logic [CHAR_W-1:0]      sel_char;
   logic [N_READERS-1:0]   sel_onehot;
   logic [CHAR_W-1:0]      mem [DEPTH];

   // Route the latched reader's finish flag and char; out-of-range selects see zeros.
   always_comb begin
      sel_fin    = 1'b0;
      sel_char   = '0;
      sel_onehot = '0;
      for (int i = 0; i < N_READERS; i++) begin
         if (int'(sel_q) == i) begin
            sel_fin       = reader_finished[i];
            sel_char      = reader_char[i*CHAR_W +: CHAR_W];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      arg_d   = arg_q;
      err_d   = 1'b0;
      flush   = 1'b0;
      wd_d    = '0;
      wr_en   = issued_q && !sel_fin &&
                (state_q == S_STREAM || state_q == S_DRAIN) &&
                !(DROP_NUL != 0 && sel_char == '0);
      pop     = (cnt_q != '0) && out_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sel_d = source_sel;
               arg_d = argument;
               if (int'(source_sel) >= N_READERS) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_ARM;
               end
            end
         end
         S_ARM: state_d = S_STREAM;
         S_STREAM: begin
            if (sel_fin) begin
               state_d = S_DRAIN;
            end else if (TIMEOUT != 0 && !wr_en && !pause_q) begin
               // Only unpaused cycles without a capture advance the watchdog.
               wd_d = wd_q + WD_W'(1);
               if (wd_q + WD_W'(1) == WD_W'(TIMEOUT)) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  flush   = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (!issued_q && cnt_q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         sel_d   = sel_q;
         arg_d   = arg_q;
         err_d   = 1'b0;
         flush   = 1'b1;
      end

      if (flush) begin
         wr_en = 1'b0;
         pop   = 1'b0;
         wd_d  = '0;
      end

      issued_d = !flush && (enable_q != '0) && !pause_q && !sel_fin;
      cnt_d    = flush ? '0 : cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
      enable_d = (state_d == S_STREAM) ? sel_onehot : '0;
   end

   // Pause is decided on post-edge occupancy so at most one char is ever in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         arg_q    <= '0;
         issued_q <= 1'b0;
         wd_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         enable_q <= '0;
         pause_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         arg_q    <= arg_d;
         issued_q <= issued_d;
         wd_q     <= wd_d;
         cnt_q    <= cnt_d;
         enable_q <= enable_d;
         pause_q  <= (cnt_d >= CNT_W'(DEPTH - 1)) || (state_d != S_STREAM);
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
         error_q  <= (state_d == S_DONE) && err_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_en) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= sel_char;
      end
   end

   assign reader_enable   = enable_q;
   assign reader_argument = arg_q;
   assign reader_pause    = pause_q;
   assign out_valid       = (cnt_q != '0);
   assign out_char        = out_valid ? mem[rd_ptr_q] : '0;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;

endmodule

// File: tb/tb_reader_sequencer.sv
// Scoreboard bench for reader_sequencer: a behavioural reader on slot 2 feeds
// directed strings, expected chars are queued at issue and popped by a monitor.
module tb_reader_sequencer;

   localparam int N    = 4;
   localparam int SW   = 3;
   localparam int CW   = 8;
   localparam int DPT  = 4;
   localparam int TMO  = 8;
   localparam int SLOT = 2;

   logic            clock = 1'b0;
   logic            resetn = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic            out_ready = 1'b0;
   logic [SW-1:0]   source_sel = '0;
   logic [7:0]      argument = '0;
   logic [N-1:0]    reader_enable;
   logic [7:0]      reader_argument;
   logic            reader_pause;
   logic [N-1:0]    reader_finished;
   logic [N*CW-1:0] reader_char;
   logic [CW-1:0]   out_char;
   logic            out_valid;
   logic            busy;
   logic            done;
   logic            error;

   reader_sequencer #(
      .N_READERS(N), .SEL_W(SW), .CHAR_W(CW), .DEPTH(DPT), .DROP_NUL(1), .TIMEOUT(TMO)
   ) dut (
      .clock(clock), .resetn(resetn), .start(start), .source_sel(source_sel),
      .argument(argument), .abort(abort), .reader_enable(reader_enable),
      .reader_argument(reader_argument), .reader_pause(reader_pause),
      .reader_finished(reader_finished), .reader_char(reader_char),
      .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   // Behavioural reader: one char per enabled, unpaused edge, then has_finished.
   byte unsigned rdStr[$];
   bit           rdStall = 1'b0;
   int           rdIdx;
   logic [7:0]   rdCh;
   logic         rdFin;

   always @(posedge clock or negedge resetn) begin
      if (!resetn || !reader_enable[SLOT]) begin
         rdIdx <= 0;
         rdCh  <= 8'h00;
         rdFin <= 1'b0;
      end else if (!reader_pause && !rdStall) begin
         if (rdIdx < rdStr.size()) begin
            rdCh  <= rdStr[rdIdx];
            rdIdx <= rdIdx + 1;
         end else begin
            rdFin <= 1'b1;
         end
      end
   end

   always_comb begin
      reader_finished       = '0;
      reader_finished[SLOT] = rdFin;
      reader_char           = {8'h44, 8'h33, 8'h22, 8'h11};
      reader_char[SLOT*CW +: CW] = rdCh;
   end

   logic [7:0] expQ[$];
   int         popCycles[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         cycle = 0;
   int         enCount = 0;
   int         doneCount = 0;
   int         curSel = SLOT;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted char and watches enable/done.
   always @(negedge clock) begin
      cycle++;
      if (resetn) begin
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL out_char_unexpected: got %0h expected none", out_char);
            end else begin
               checkOutput("out_char", {24'h0, out_char}, {24'h0, expQ.pop_front()});
               popCycles.push_back(cycle);
            end
         end
         if (reader_enable != '0) begin
            enCount++;
            checkOutput("enable_onehot", {28'h0, reader_enable}, 32'(1) << curSel);
         end
         if (done) doneCount++;
      end
   end

   task automatic stepN(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [SW-1:0] sel, input logic [7:0] arg);
      source_sel = sel;
      argument   = arg;
      start      = 1'b1;
      stepN(1);
      start      = 1'b0;
   endtask

   task automatic waitDone(input string name, input logic expErr, output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         stepN(1);
         cyc++;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s_done_timeout: got no done expected done", name);
      end else begin
         checkOutput({name, "_error"}, {31'h0, error}, {31'h0, expErr});
         stepN(1);
         checkOutput({name, "_done_pulse"}, {31'h0, done}, 32'h0);
      end
   endtask

   task automatic loadStr(input string s);
      rdStr.delete();
      for (int i = 0; i < s.len(); i++) rdStr.push_back(s[i]);
   endtask

   task automatic expectStr(input string s);
      for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
   endtask

   initial begin
      int cyc;
      int base;

      stepN(2);
      checkOutput("rst_enable", {28'h0, reader_enable}, 32'h0);
      checkOutput("rst_pause", {31'h0, reader_pause}, 32'h1);
      checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("rst_char", {24'h0, out_char}, 32'h0);
      checkOutput("rst_busy_done_error", {29'h0, busy, done, error}, 32'h0);
      resetn = 1'b1;
      stepN(2);

      // "test" with the consumer always ready: four back-to-back chars.
      loadStr("test");
      expectStr("test");
      popCycles.delete();
      out_ready = 1'b1;
      applyStimulus(3'(SLOT), 8'h5A);
      checkOutput("t1_argument", {24'h0, reader_argument}, 32'h5A);
      checkOutput("t1_busy", {31'h0, busy}, 32'h1);
      waitDone("t1", 1'b0, cyc);
      checkOutput("t1_all_delivered", expQ.size(), 32'h0);
      checkOutput("t1_pop_count", popCycles.size(), 32'h4);
      if (popCycles.size() == 4)
         checkOutput("t1_consecutive", popCycles[3] - popCycles[0], 32'h3);
      stepN(2);

      // Consumer stalls for 10 cycles on an 8-char stream; FIFO fills and pauses.
      loadStr("sequence");
      expectStr("sequence");
      out_ready = 1'b0;
      applyStimulus(3'(SLOT), 8'h21);
      stepN(5);
      applyStimulus(3'd1, 8'h77);
      stepN(4);
      checkOutput("t2_pause", {31'h0, reader_pause}, 32'h1);
      checkOutput("t2_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("t2_enable", {28'h0, reader_enable}, 32'h4);
      checkOutput("t2_arg_kept", {24'h0, reader_argument}, 32'h21);
      out_ready = 1'b1;
      waitDone("t2", 1'b0, cyc);
      checkOutput("t2_all_delivered", expQ.size(), 32'h0);
      stepN(2);

      // Out-of-range select ends the job with an error and never enables a reader.
      base = enCount;
      applyStimulus(3'd5, 8'h01);
      waitDone("t3", 1'b1, cyc);
      checkOutput("t3_done_latency", {31'h0, cyc > 1}, 32'h0);
      checkOutput("t3_no_enable", enCount - base, 32'h0);
      stepN(2);

      // Stalled reader: watchdog fires after TMO streaming cycles.
      rdStall = 1'b1;
      loadStr("");
      base = enCount;
      applyStimulus(3'(SLOT), 8'h02);
      waitDone("t4", 1'b1, cyc);
      checkOutput("t4_stream_cycles", enCount - base, TMO);
      checkOutput("t4_fifo_empty", {31'h0, out_valid}, 32'h0);
      rdStall = 1'b0;
      stepN(2);

      // Abort with two chars buffered: immediate return to idle, no done pulse.
      loadStr("xyzw");
      out_ready = 1'b0;
      applyStimulus(3'(SLOT), 8'h03);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         stepN(1);
         cyc++;
      end
      stepN(1);
      checkOutput("t5_buffered", {31'h0, out_valid}, 32'h1);
      base = doneCount;
      abort = 1'b1;
      stepN(1);
      abort = 1'b0;
      checkOutput("t5_busy", {31'h0, busy}, 32'h0);
      checkOutput("t5_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("t5_enable", {28'h0, reader_enable}, 32'h0);
      stepN(5);
      checkOutput("t5_no_done", doneCount - base, 32'h0);
      out_ready = 1'b1;
      stepN(2);

      // NUL chars are discarded.
      rdStr.delete();
      rdStr.push_back(8'h61);
      rdStr.push_back(8'h00);
      rdStr.push_back(8'h62);
      expectStr("ab");
      applyStimulus(3'(SLOT), 8'h04);
      waitDone("t6", 1'b0, cyc);
      checkOutput("t6_all_delivered", expQ.size(), 32'h0);
      stepN(2);

      // Asynchronous reset mid-stream forces every output to its reset value at once.
      loadStr("reset");
      out_ready = 1'b0;
      applyStimulus(3'(SLOT), 8'h05);
      stepN(4);
      checkOutput("rst2_busy_before", {31'h0, busy}, 32'h1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("rst2_enable", {28'h0, reader_enable}, 32'h0);
      checkOutput("rst2_pause", {31'h0, reader_pause}, 32'h1);
      checkOutput("rst2_valid_char", {23'h0, out_valid, out_char}, 32'h0);
      checkOutput("rst2_busy_done_error", {29'h0, busy, done, error}, 32'h0);
      checkOutput("rst2_argument", {24'h0, reader_argument}, 32'h0);
      stepN(1);
      resetn = 1'b1;
      stepN(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
